// File: rtl/vc_mem_responder_if.sv
// Requester/responder bus between the victim cache write-back port and the memory model.
interface vc_mem_responder_if #(
  parameter int TAG_WIDTH  = 20,
  parameter int LINE_BYTES = 16
);
  logic                    mem_req;
  logic                    mem_req_write;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic [LINE_BYTES*8-1:0] mem_req_wdata;
  logic                    mem_resp_valid;
  logic [LINE_BYTES*8-1:0] mem_resp_rdata;

  modport master (
    output mem_req, mem_req_write, mem_req_tag, mem_req_wdata,
    input  mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req, mem_req_write, mem_req_tag, mem_req_wdata,
    output mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/vc_mem_responder.sv
// Line-granular memory model: fixed-latency write-back/read responder with protocol checking.
// States: IDLE wait for req | BUSY latency countdown | RESP pulse + commit | DRAIN wait for req low
module vc_mem_responder #(
  parameter int TAG_WIDTH    = 20,
  parameter int LINE_BYTES   = 16,
  parameter int ADDR_BITS    = 6,
  parameter int RESP_LATENCY = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  vc_mem_responder_if.slave       bus,
  output logic [CNT_WIDTH-1:0]    o_wr_count,
  output logic [CNT_WIDTH-1:0]    o_rd_count,
  output logic                    o_proto_err,
  input  logic [ADDR_BITS-1:0]    i_dbg_rd_addr,
  output logic [LINE_BYTES*8-1:0] o_dbg_rd_data
);
  localparam int LW = LINE_BYTES * 8;
  localparam logic [3:0] LAT_LOAD = 4'(RESP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_lat_cnt;
  logic                  r_write;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [LW-1:0]         r_wdata;
  logic                  r_resp_valid;
  logic [CNT_WIDTH-1:0]  r_wr_count;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic                  r_proto_err;
  logic [LW-1:0]         r_mem [2**ADDR_BITS];

  logic                  w_accept;
  logic                  w_abort;
  logic                  w_mismatch;
  logic                  w_commit_wr;
  logic                  w_commit_rd;
  logic [ADDR_BITS-1:0]  w_idx;

  assign w_idx = r_tag[ADDR_BITS-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.mem_req) w_next = (RESP_LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (!bus.mem_req)          w_next = IDLE;
               else if (r_lat_cnt <= 4'd1) w_next = RESP;
      RESP:    w_next = DRAIN;
      DRAIN:   if (!bus.mem_req) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept    = (r_state == IDLE) && bus.mem_req;
    w_abort     = (r_state == BUSY) && !bus.mem_req;
    w_mismatch  = (r_state == BUSY) && bus.mem_req &&
                  ((bus.mem_req_tag != r_tag) || (bus.mem_req_write != r_write));
    w_commit_wr = (r_state == RESP) && r_write;
    w_commit_rd = (r_state == RESP) && !r_write;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lat_cnt    <= '0;
      r_write      <= 1'b0;
      r_tag        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_wr_count   <= '0;
      r_rd_count   <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_resp_valid <= (w_next == RESP);
      if (w_accept) begin
        r_write   <= bus.mem_req_write;
        r_tag     <= bus.mem_req_tag;
        r_wdata   <= bus.mem_req_wdata;
        r_lat_cnt <= LAT_LOAD;
      end else if ((r_state == BUSY) && (r_lat_cnt != 4'd0)) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end
      if (w_abort || w_mismatch) r_proto_err <= 1'b1;
      if (w_commit_wr && (r_wr_count != '1)) r_wr_count <= r_wr_count + 1'b1;
      if (w_commit_rd && (r_rd_count != '1)) r_rd_count <= r_rd_count + 1'b1;
    end
  end

  // Array is deliberately not reset; a reset in the RESP cycle still suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_commit_wr) r_mem[w_idx] <= r_wdata;
  end

  assign bus.mem_resp_valid = r_resp_valid;
  assign bus.mem_resp_rdata = w_commit_rd ? r_mem[w_idx] : '0;
  assign o_wr_count         = r_wr_count;
  assign o_rd_count         = r_rd_count;
  assign o_proto_err        = r_proto_err;
  assign o_dbg_rd_data      = r_mem[i_dbg_rd_addr];
endmodule

// File: tb/tb_vc_mem_responder.sv
// Scoreboard bench: DUT 0 with latency 2, DUT 1 with latency 1, directed transactions.
module tb_vc_mem_responder;
  typedef struct {
    int           dut;
    int           cyc;
    logic [127:0] rdata;
  } exp_t;

  logic         clk = 1'b0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_err = 0;
  exp_t         q[$];

  logic         rst   [2];
  logic         req   [2];
  logic         wr_v  [2];
  logic [19:0]  tag_v [2];
  logic [127:0] wdata [2];
  logic [5:0]   dbg_addr [2];
  logic [127:0] dbg_data [2];
  logic [15:0]  wr_cnt [2];
  logic [15:0]  rd_cnt [2];
  logic         proto  [2];

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D_3C = {16{8'h3C}};
  localparam logic [127:0] D_11 = {16{8'h11}};
  localparam logic [127:0] D_77 = {16{8'h77}};
  localparam logic [127:0] D_B1 = {8{16'hB1C2}};
  localparam logic [127:0] D_E9 = {4{32'hE9F0_1234}};

  vc_mem_responder_if #(.TAG_WIDTH(20), .LINE_BYTES(16)) bus_a ();
  vc_mem_responder_if #(.TAG_WIDTH(20), .LINE_BYTES(16)) bus_b ();

  assign bus_a.mem_req       = req[0];
  assign bus_a.mem_req_write = wr_v[0];
  assign bus_a.mem_req_tag   = tag_v[0];
  assign bus_a.mem_req_wdata = wdata[0];
  assign bus_b.mem_req       = req[1];
  assign bus_b.mem_req_write = wr_v[1];
  assign bus_b.mem_req_tag   = tag_v[1];
  assign bus_b.mem_req_wdata = wdata[1];

  vc_mem_responder #(.RESP_LATENCY(2)) u_dut_a (
    .i_clk(clk), .i_rst(rst[0]), .bus(bus_a),
    .o_wr_count(wr_cnt[0]), .o_rd_count(rd_cnt[0]), .o_proto_err(proto[0]),
    .i_dbg_rd_addr(dbg_addr[0]), .o_dbg_rd_data(dbg_data[0])
  );

  vc_mem_responder #(.RESP_LATENCY(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst[1]), .bus(bus_b),
    .o_wr_count(wr_cnt[1]), .o_rd_count(rd_cnt[1]), .o_proto_err(proto[1]),
    .i_dbg_rd_addr(dbg_addr[1]), .o_dbg_rd_data(dbg_data[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [127:0] rd);
    exp_t e;
    if (v === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp dut%0d: got pulse at cycle %0d expected none", d, cyc);
      end else begin
        e = q.pop_front();
        if (e.dut != d || e.cyc != cyc) begin
          n_err++;
          $display("FAIL resp_timing: got dut%0d cycle %0d expected dut%0d cycle %0d",
                   d, cyc, e.dut, e.cyc);
        end
        chk("resp_rdata", rd, e.rdata);
      end
    end else begin
      chk("rdata_idle", rd, '0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.mem_resp_valid, bus_a.mem_resp_rdata);
    mon(1, bus_b.mem_resp_valid, bus_b.mem_resp_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic wait_resp(input int d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (((d == 0) ? bus_a.mem_resp_valid : bus_b.mem_resp_valid) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_err++;
      $display("FAIL resp_timeout dut%0d: got no pulse in 20 cycles expected one", d);
    end
  endtask

  // Issue at current cycle, hold until response (+hold cycles), drop, then idle one cycle.
  task automatic txn(input int d, input bit wr, input logic [19:0] tag,
                     input logic [127:0] wd, input logic [127:0] exp_rd, input int hold);
    exp_t e;
    e.dut = d;
    e.cyc = cyc + lat_of(d);
    e.rdata = wr ? '0 : exp_rd;
    q.push_back(e);
    req[d] = 1'b1; wr_v[d] = wr; tag_v[d] = tag; wdata[d] = wd;
    wait_resp(d);
    tick();
    repeat (hold) tick();
    req[d] = 1'b0;
    tick();
  endtask

  task automatic chk_dbg(input int d, input logic [5:0] a, input logic [127:0] exp);
    dbg_addr[d] = a;
    @(negedge clk);
    chk($sformatf("dbg_dut%0d_idx%0d", d, a), dbg_data[d], exp);
    tick();
  endtask

  task automatic chk_state(input int d, input logic [15:0] wr_e, input logic [15:0] rd_e,
                           input logic pe_e);
    @(negedge clk);
    chk($sformatf("wr_count_dut%0d", d), 128'(wr_cnt[d]), 128'(wr_e));
    chk($sformatf("rd_count_dut%0d", d), 128'(rd_cnt[d]), 128'(rd_e));
    chk($sformatf("proto_err_dut%0d", d), 128'(proto[d]), 128'(pe_e));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b1; wr_v[d] = 1'b1; tag_v[d] = 20'h5;
      wdata[d] = D_77; dbg_addr[d] = '0;
    end
    // Reset with mem_req held high: must be ignored.
    tick(); tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid_dut%0d", d),
          128'((d == 0) ? bus_a.mem_resp_valid : bus_b.mem_resp_valid), '0);
      chk($sformatf("rst_wr_dut%0d", d), 128'(wr_cnt[d]), '0);
      chk($sformatf("rst_rd_dut%0d", d), 128'(rd_cnt[d]), '0);
      chk($sformatf("rst_proto_dut%0d", d), 128'(proto[d]), '0);
    end
    tick();
    for (int d = 0; d < 2; d++) begin rst[d] = 1'b0; req[d] = 1'b0; end
    tick();

    // Write, then aliased read through the upper tag bits.
    txn(0, 1'b1, 20'h00005, D_A5, '0, 0);
    chk_dbg(0, 6'd5, D_A5);
    chk_state(0, 16'd1, 16'd0, 1'b0);
    txn(0, 1'b0, 20'h00045, '0, D_A5, 0);
    chk_state(0, 16'd1, 16'd1, 1'b0);

    // Hold after response: no second pulse; re-request right after drop.
    txn(0, 1'b0, 20'h00005, '0, D_A5, 4);
    txn(0, 1'b0, 20'hFFFC5, '0, D_A5, 0);
    chk_state(0, 16'd1, 16'd3, 1'b0);

    // Withdraw during BUSY.
    req[0] = 1'b1; wr_v[0] = 1'b1; tag_v[0] = 20'h5; wdata[0] = D_3C;
    tick();
    req[0] = 1'b0;
    repeat (4) tick();
    chk_state(0, 16'd1, 16'd3, 1'b1);
    chk_dbg(0, 6'd5, D_A5);

    // Reset clears flags and counters but not the array.
    rst[0] = 1'b1; tick(); tick(); rst[0] = 1'b0; tick();
    chk_state(0, 16'd0, 16'd0, 1'b0);
    chk_dbg(0, 6'd5, D_A5);

    // Tag changes during BUSY: flagged, completes with captured tag.
    begin
      exp_t e;
      e.dut = 0; e.cyc = cyc + 2; e.rdata = '0;
      q.push_back(e);
    end
    req[0] = 1'b1; wr_v[0] = 1'b1; tag_v[0] = 20'h7; wdata[0] = D_11;
    tick();
    tag_v[0] = 20'h8;
    wait_resp(0);
    tick();
    req[0] = 1'b0;
    tick();
    chk_dbg(0, 6'd7, D_11);
    chk_state(0, 16'd1, 16'd0, 1'b1);

    // Reset while BUSY: nothing lands, nothing responds.
    req[0] = 1'b1; wr_v[0] = 1'b1; tag_v[0] = 20'h9; wdata[0] = D_77;
    tick();
    rst[0] = 1'b1; req[0] = 1'b0;
    tick(); tick();
    rst[0] = 1'b0;
    repeat (4) tick();
    chk_state(0, 16'd0, 16'd0, 1'b0);
    dbg_addr[0] = 6'd9;
    @(negedge clk);
    n_checks++;
    if (dbg_data[0] === D_77) begin
      n_err++;
      $display("FAIL rst_busy_no_write: got %0h expected entry not written", dbg_data[0]);
    end
    tick();

    // Latency 1: back-to-back evictions, then aliased read.
    txn(1, 1'b1, 20'h00010, D_B1, '0, 0);
    txn(1, 1'b1, 20'h00021, D_E9, '0, 0);
    chk_dbg(1, 6'h10, D_B1);
    chk_dbg(1, 6'h21, D_E9);
    chk_state(1, 16'd2, 16'd0, 1'b0);
    txn(1, 1'b0, 20'h00050, '0, D_B1, 2);
    chk_state(1, 16'd2, 16'd1, 1'b0);
    rst[1] = 1'b1; tick(); rst[1] = 1'b0; tick();
    chk_state(1, 16'd0, 16'd0, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", 128'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
